hssl_cfg_bank: RTL and testbench

//  APB-programmable configuration bank for the HSSL packet path: control regs, key/mask/route

---
 rtl/hssl_cfg_pkg.sv | 25 ++
 rtl/hssl_evt_counter.sv | 35 +++
 rtl/hssl_cfg_bank.sv | 160 ++++++++++++++++
 tb/tb_hssl_cfg_bank.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hssl_cfg_pkg.sv
// Shared section decode, constants and helpers for the HSSL configuration bank.
// Pure declarations: no latency, no backpressure.
package hssl_cfg_pkg;

  localparam int SEC_W = 3;
  localparam logic [31:0] BANK_ID_DEF = 32'h5346_0002;
  localparam int ID_SIZE = 1;

  typedef enum logic [SEC_W-1:0] {
    SEC_CTRL  = 3'd0,
    SEC_KEY   = 3'd1,
    SEC_MASK  = 3'd2,
    SEC_ROUTE = 3'd3,
    SEC_CNT   = 3'd4,
    SEC_ID    = 3'd5,
    SEC_RSV6  = 3'd6,
    SEC_RSV7  = 3'd7
  } sec_e;

  // Index bits needed to address n entries, never less than one.
  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hssl_evt_counter.sv
// Saturating event counter with synchronous clear; clear plus event lands on 1.
// Latency one cycle from evt_i/clr_i to cnt_o; no backpressure.
module hssl_evt_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             evt_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = evt_i ? CNT_W'(1) : '0;
    end else if (evt_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hssl_cfg_bank.sv
// APB config bank for the HSSL path: ctrl regs, key/mask/route table, event counters, ID word.
// Every transfer takes one wait state; pready pulses for one cycle, psel drop is not honoured.
module hssl_cfg_bank
  import hssl_cfg_pkg::*;
#(
  parameter int          NUM_CTRL    = 4,
  parameter int          NUM_ENTRIES = 32,
  parameter int          ROUTE_W     = 3,
  parameter int          NUM_CNTRS   = 8,
  parameter int          REG_SEC_LSB = 8,
  parameter int          REG_NUM_LSB = 2,
  parameter int          IDX_W       = REG_SEC_LSB - REG_NUM_LSB,
  parameter logic [31:0] BANK_ID     = BANK_ID_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  apb_psel_in,
  input  logic                                  apb_penable_in,
  input  logic                                  apb_pwrite_in,
  input  logic [39:0]                           apb_paddr_in,
  input  logic [31:0]                           apb_pwdata_in,
  output logic [31:0]                           apb_prdata_out,
  output logic                                  apb_pready_out,
  output logic                                  apb_pslverr_out,
  input  logic [NUM_CNTRS-1:0]                  evt_in,
  output logic [NUM_CTRL-1:0][31:0]             reg_ctrl_out,
  output logic [NUM_ENTRIES-1:0][31:0]          reg_key_out,
  output logic [NUM_ENTRIES-1:0][31:0]          reg_mask_out,
  output logic [NUM_ENTRIES-1:0][ROUTE_W-1:0]   reg_route_out,
  output logic                                  tbl_upd_out,
  output logic [IDX_W-1:0]                      tbl_upd_idx_out
);

  localparam int CTRL_AW = idx_bits(NUM_CTRL);
  localparam int ENT_AW  = idx_bits(NUM_ENTRIES);
  localparam int CNT_AW  = idx_bits(NUM_CNTRS);

  typedef enum logic {ST_IDLE, ST_DONE} state_e;

  state_e                               state_q;
  logic [31:0]                          prdata_q;
  logic                                 pready_q;
  logic                                 pslverr_q;
  logic                                 tbl_upd_q;
  logic [IDX_W-1:0]                     tbl_upd_idx_q;
  logic [NUM_CTRL-1:0][31:0]            ctrl_q;
  logic [NUM_ENTRIES-1:0][31:0]         key_q;
  logic [NUM_ENTRIES-1:0][31:0]         mask_q;
  logic [NUM_ENTRIES-1:0][ROUTE_W-1:0]  route_q;
  logic [NUM_CNTRS-1:0][31:0]           cnt;
  logic [NUM_CNTRS-1:0]                 cnt_clr;

  sec_e             sec;
  logic [IDX_W-1:0] idx;
  logic [31:0]      idx32;
  logic             access;
  logic             err_d;
  logic             wr_en;
  logic [31:0]      rd_data_d;
  logic             unused_paddr;

  assign sec    = sec_e'(apb_paddr_in[REG_SEC_LSB +: SEC_W]);
  assign idx    = apb_paddr_in[REG_NUM_LSB +: IDX_W];
  assign idx32  = 32'(idx);
  assign access = (state_q == ST_IDLE) && apb_psel_in && apb_penable_in;
  assign wr_en  = access && apb_pwrite_in && !err_d;
  assign unused_paddr = ^{apb_paddr_in[39:REG_SEC_LSB+SEC_W], apb_paddr_in[REG_NUM_LSB-1:0]};

  always_comb begin
    err_d = 1'b1;
    case (sec)
      SEC_CTRL:                     err_d = (idx32 >= NUM_CTRL);
      SEC_KEY, SEC_MASK, SEC_ROUTE: err_d = (idx32 >= NUM_ENTRIES);
      SEC_CNT:                      err_d = (idx32 >= NUM_CNTRS);
      SEC_ID:                       err_d = apb_pwrite_in || (idx32 >= ID_SIZE);
      default:                      err_d = 1'b1;
    endcase
  end

  // Out-of-range indices may alias here; err_d masks the result to zero.
  always_comb begin
    rd_data_d = '0;
    case (sec)
      SEC_CTRL:  rd_data_d = ctrl_q[idx[CTRL_AW-1:0]];
      SEC_KEY:   rd_data_d = key_q[idx[ENT_AW-1:0]];
      SEC_MASK:  rd_data_d = mask_q[idx[ENT_AW-1:0]];
      SEC_ROUTE: rd_data_d = 32'(route_q[idx[ENT_AW-1:0]]);
      SEC_CNT:   rd_data_d = cnt[idx[CNT_AW-1:0]];
      SEC_ID:    rd_data_d = BANK_ID;
      default:   rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      prdata_q      <= '0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      tbl_upd_q     <= 1'b0;
      tbl_upd_idx_q <= '0;
      ctrl_q        <= '0;
      key_q         <= '0;
      mask_q        <= '0;
      route_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            state_q       <= ST_DONE;
            pready_q      <= 1'b1;
            pslverr_q     <= err_d;
            prdata_q      <= (err_d || apb_pwrite_in) ? '0 : rd_data_d;
            tbl_upd_q     <= wr_en && (sec inside {SEC_KEY, SEC_MASK, SEC_ROUTE});
            tbl_upd_idx_q <= idx;
            if (wr_en) begin
              case (sec)
                SEC_CTRL:  ctrl_q[idx[CTRL_AW-1:0]] <= apb_pwdata_in;
                SEC_KEY:   key_q[idx[ENT_AW-1:0]]   <= apb_pwdata_in;
                SEC_MASK:  mask_q[idx[ENT_AW-1:0]]  <= apb_pwdata_in;
                SEC_ROUTE: route_q[idx[ENT_AW-1:0]] <= apb_pwdata_in[ROUTE_W-1:0];
                default: ;
              endcase
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          tbl_upd_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CNTRS; g++) begin : g_cnt
    assign cnt_clr[g] = wr_en && (sec == SEC_CNT) && (idx[CNT_AW-1:0] == CNT_AW'(g));

    hssl_evt_counter #(.CNT_W(32)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (cnt_clr[g]),
      .evt_i (evt_in[g]),
      .cnt_o (cnt[g])
    );
  end

  assign apb_prdata_out  = prdata_q;
  assign apb_pready_out  = pready_q;
  assign apb_pslverr_out = pslverr_q;
  assign tbl_upd_out     = tbl_upd_q;
  assign tbl_upd_idx_out = tbl_upd_idx_q;
  assign reg_ctrl_out    = ctrl_q;
  assign reg_key_out     = key_q;
  assign reg_mask_out    = mask_q;
  assign reg_route_out   = route_q;

endmodule

// File: tb/tb_hssl_cfg_bank.sv
// Bench for hssl_cfg_bank: directed and random APB traffic against an array-based register model.
// A narrow standalone counter instance exercises saturation in a reachable number of events.
module tb_hssl_cfg_bank;

  logic               clk = 1'b0;
  logic               reset;
  logic               psel, penable, pwrite;
  logic [39:0]        paddr;
  logic [31:0]        pwdata;
  logic [31:0]        prdata;
  logic               pready, pslverr;
  logic [7:0]         evt_in;
  logic [3:0][31:0]   reg_ctrl;
  logic [31:0][31:0]  reg_key;
  logic [31:0][31:0]  reg_mask;
  logic [31:0][2:0]   reg_route;
  logic               tbl_upd;
  logic [5:0]         tbl_upd_idx;

  logic               sat_clr, sat_evt;
  logic [3:0]         sat_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ctrl_m [4];
  logic [31:0] key_m  [32];
  logic [31:0] mask_m [32];
  logic [31:0] route_m[32];
  logic [31:0] cnt_m  [8];

  always #5 clk = ~clk;

  hssl_cfg_bank dut (
    .clk             (clk),
    .reset           (reset),
    .apb_psel_in     (psel),
    .apb_penable_in  (penable),
    .apb_pwrite_in   (pwrite),
    .apb_paddr_in    (paddr),
    .apb_pwdata_in   (pwdata),
    .apb_prdata_out  (prdata),
    .apb_pready_out  (pready),
    .apb_pslverr_out (pslverr),
    .evt_in          (evt_in),
    .reg_ctrl_out    (reg_ctrl),
    .reg_key_out     (reg_key),
    .reg_mask_out    (reg_mask),
    .reg_route_out   (reg_route),
    .tbl_upd_out     (tbl_upd),
    .tbl_upd_idx_out (tbl_upd_idx)
  );

  hssl_evt_counter #(.CNT_W(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .clr_i (sat_clr),
    .evt_i (sat_evt),
    .cnt_o (sat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      key_m[i] = '0; mask_m[i] = '0; route_m[i] = '0;
    end
    for (int i = 0; i < 4; i++) ctrl_m[i] = '0;
    for (int i = 0; i < 8; i++) cnt_m[i] = '0;
  endtask

  task automatic model_evt(input logic [7:0] evt);
    for (int b = 0; b < 8; b++)
      if (evt[b] && cnt_m[b] != 32'hFFFF_FFFF) cnt_m[b] = cnt_m[b] + 1;
  endtask

  // Register-map rules: section sizes, legality, write side effects.
  task automatic model_xfer(input bit wr, input int sec, input int idx, input logic [31:0] d,
                            input logic [7:0] evt, output logic [31:0] rd, output logic err,
                            output logic upd);
    int size;
    case (sec)
      0:       size = 4;
      1, 2, 3: size = 32;
      4:       size = 8;
      5:       size = wr ? 0 : 1;
      default: size = 0;
    endcase
    err = (idx >= size);
    rd  = '0;
    upd = 1'b0;
    if (!err && !wr) begin
      case (sec)
        0: rd = ctrl_m[idx];
        1: rd = key_m[idx];
        2: rd = mask_m[idx];
        3: rd = route_m[idx];
        4: rd = cnt_m[idx];
        default: rd = 32'h5346_0002;
      endcase
    end
    for (int b = 0; b < 8; b++) begin
      if (!err && wr && sec == 4 && idx == b) cnt_m[b] = {31'd0, evt[b]};
      else if (evt[b] && cnt_m[b] != 32'hFFFF_FFFF) cnt_m[b] = cnt_m[b] + 1;
    end
    if (!err && wr) begin
      case (sec)
        0: ctrl_m[idx] = d;
        1: key_m[idx] = d;
        2: mask_m[idx] = d;
        3: route_m[idx] = d % 8;
        default: ;
      endcase
      upd = (sec >= 1 && sec <= 3);
    end
  endtask

  // Two-phase APB transfer; checks the single wait state and the one-cycle pready pulse.
  task automatic apb(input bit wr, input int sec, input int idx, input logic [31:0] d,
                     input logic [7:0] evt, output logic [31:0] rd, output logic err,
                     output logic upd, output logic [5:0] upd_idx);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; pwdata = d;
    paddr = 40'(sec) * 40'd256 + 40'(idx) * 40'd4;
    @(posedge clk); #1;
    penable = 1'b1; evt_in = evt;
    @(negedge clk);
    chk("wait_state_pready", 32'(pready), 32'd0);
    @(posedge clk); #1;
    evt_in = '0;
    @(negedge clk);
    chk("done_pready", 32'(pready), 32'd1);
    rd = prdata; err = pslverr; upd = tbl_upd; upd_idx = tbl_upd_idx;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("pready_one_cycle", 32'(pready), 32'd0);
    chk("tbl_upd_one_cycle", 32'(tbl_upd), 32'd0);
  endtask

  task automatic xfer(input string tag, input bit wr, input int sec, input int idx,
                      input logic [31:0] d, input logic [7:0] evt);
    logic [31:0] rd, exp_rd;
    logic err, exp_err, upd, exp_upd;
    logic [5:0] upd_idx;
    model_xfer(wr, sec, idx, d, evt, exp_rd, exp_err, exp_upd);
    apb(wr, sec, idx, d, evt, rd, err, upd, upd_idx);
    chk({tag, "_pslverr"}, 32'(err), 32'(exp_err));
    if (!wr || exp_err) chk({tag, "_prdata"}, rd, exp_rd);
    chk({tag, "_tbl_upd"}, 32'(upd), 32'(exp_upd));
    if (exp_upd) chk({tag, "_tbl_upd_idx"}, 32'(upd_idx), 32'(idx));
  endtask

  task automatic pulse_evt(input logic [7:0] evt);
    @(posedge clk); #1; evt_in = evt;
    @(posedge clk); #1; evt_in = '0;
    model_evt(evt);
  endtask

  task automatic check_outputs(input string tag);
    int bad = 0;
    for (int i = 0; i < 4; i++)  if (reg_ctrl[i] !== ctrl_m[i]) bad++;
    for (int i = 0; i < 32; i++) begin
      if (reg_key[i]  !== key_m[i])          bad++;
      if (reg_mask[i] !== mask_m[i])         bad++;
      if (32'(reg_route[i]) !== route_m[i]) bad++;
    end
    chk({tag, "_reg_outputs_mismatches"}, 32'(bad), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int sec, idx;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; evt_in = '0;
    sat_clr = 0; sat_evt = 0;
    do_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_tbl_upd", 32'(tbl_upd), 32'd0);
    check_outputs("rst");
    xfer("id_read", 0, 5, 0, '0, '0);
    xfer("key0_read", 0, 1, 0, '0, '0);

    // Table writes and readback.
    xfer("key5_wr", 1, 1, 5, 32'hDEAD_BEEF, '0);
    xfer("mask5_wr", 1, 2, 5, 32'h0F0F_A5A5, '0);
    xfer("key5_rd", 0, 1, 5, '0, '0);
    xfer("mask5_rd", 0, 2, 5, '0, '0);
    xfer("route31_wr", 1, 3, 31, 32'hFFFF_FFFF, '0);
    xfer("route31_rd", 0, 3, 31, '0, '0);
    xfer("route32_wr", 1, 3, 32, 32'h0000_0005, '0);
    xfer("ctrl3_wr", 1, 0, 3, 32'h1234_5678, '0);
    xfer("ctrl4_wr", 1, 0, 4, 32'hFFFF_0000, '0);

    // Illegal sections and writes to read-only words.
    xfer("id_wr", 1, 5, 0, 32'hCAFE_F00D, '0);
    xfer("id1_rd", 0, 5, 1, '0, '0);
    xfer("sec6_rd", 0, 6, 0, '0, '0);
    xfer("sec7_wr", 1, 7, 3, 32'h1111_1111, '0);
    check_outputs("after_errors");

    // Event counters.
    for (int i = 0; i < 5; i++) pulse_evt(8'h04);
    xfer("cnt2_rd", 0, 4, 2, '0, '0);
    xfer("cnt2_rd_with_evt", 0, 4, 2, '0, 8'h04);
    xfer("cnt2_clr_with_evt", 1, 4, 2, 32'h0, 8'h05);
    xfer("cnt2_after_clr", 0, 4, 2, '0, '0);
    xfer("cnt0_rd", 0, 4, 0, '0, '0);
    xfer("cnt8_wr", 1, 4, 8, 32'h0, '0);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      sec = $urandom_range(0, 7);
      idx = (sec >= 1 && sec <= 3) ? $urandom_range(0, 35) : $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) pulse_evt(8'($urandom));
      xfer("rand", 1'($urandom_range(0, 1)), sec, idx, $urandom,
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end
    check_outputs("after_random");
    for (int i = 0; i < 8; i++) xfer("cnt_sweep", 0, 4, i, '0, '0);

    // Reset asserted while a write is in its DONE cycle.
    do_reset();
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 40'h0000_0004; pwdata = 32'hA5A5_A5A5;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    chk("rst_in_done_pready", 32'(pready), 32'd0);
    chk("rst_in_done_ctrl1", reg_ctrl[1], 32'd0);
    psel = 0; penable = 0;
    @(posedge clk); #1 reset = 0;
    model_reset();
    @(negedge clk);
    chk("post_rst_ctrl1", reg_ctrl[1], 32'd0);
    xfer("post_rst_ctrl1_rd", 0, 0, 1, '0, '0);

    // Saturation on the narrow counter: 14 events reach 'hE, three more stick at 'hF.
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1 sat_evt = 1;
      @(posedge clk); #1 sat_evt = 0;
    end
    @(negedge clk);
    chk("sat_pre", 32'(sat_cnt), 32'hE);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 sat_evt = 1;
      @(posedge clk); #1 sat_evt = 0;
    end
    @(negedge clk);
    chk("sat_hold", 32'(sat_cnt), 32'hF);
    @(posedge clk); #1 begin sat_clr = 1; sat_evt = 1; end
    @(posedge clk); #1 begin sat_clr = 0; sat_evt = 0; end
    @(negedge clk);
    chk("sat_clr_evt", 32'(sat_cnt), 32'h1);
    @(posedge clk); #1 sat_clr = 1;
    @(posedge clk); #1 sat_clr = 0;
    @(negedge clk);
    chk("sat_clr", 32'(sat_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
